// File: rtl/dcnn_reg_pkg.sv
// Shared types for the kernel-row register bank.
// Holds the MODE encodings used by the bank and its bench.
package dcnn_reg_pkg;

    // Operating modes of the bank, sampled only while EN is high.
    typedef enum logic [1:0] {
        MODE_HOLD  = 2'b00,
        MODE_SHIFT = 2'b01,
        MODE_LOAD  = 2'b10,
        MODE_CLEAR = 2'b11
    } reg_mode_t;

endpackage

// File: rtl/register_stage.sv
// One WIDTH-bit stage of the kernel-row register bank.
// Ports:
//   clk, rst  : rising-edge clock, async active-high reset
//   en        : write enable (shift or load)
//   clr       : synchronous clear, wins over en
//   sel_par   : 1 = take par_d, 0 = take ser_d
//   ser_d     : serial neighbour (previous stage or Din)
//   par_d     : parallel slice from Pin
//   q         : stage contents
module register_stage #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             clr,
    input  logic             sel_par,
    input  logic [WIDTH-1:0] ser_d,
    input  logic [WIDTH-1:0] par_d,
    output logic [WIDTH-1:0] q
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= '0;
        end else if (clr) begin
            q <= '0;
        end else if (en) begin
            q <= sel_par ? par_d : ser_d;
        end
    end

endmodule

// File: rtl/register_shift_bank.sv
// DEPTH x WIDTH shift/load register bank holding one kernel-row
// window between the feature-map reader and the MAC array.
// Ports:
//   CLK, RST : rising-edge clock, async active-high reset
//   EN       : operation enable; 0 holds regardless of MODE
//   MODE     : 00 hold, 01 shift-in, 10 parallel load, 11 clear
//   Din      : serial input into stage 0
//   Pin      : parallel data, slice i -> stage i
//   Pout     : all stages, same slicing as Pin
//   Dout     : stage DEPTH-1 (oldest word)
//   COUNT    : number of valid words, 0..DEPTH (saturating)
//   FULL     : COUNT == DEPTH
//   EVICT    : one-cycle pulse after a shift that dropped a valid word
module register_shift_bank
    import dcnn_reg_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int DEPTH = 5
) (
    input  logic                       CLK,
    input  logic                       RST,
    input  logic                       EN,
    input  logic [1:0]                 MODE,
    input  logic [WIDTH-1:0]           Din,
    input  logic [DEPTH*WIDTH-1:0]     Pin,
    output logic [DEPTH*WIDTH-1:0]     Pout,
    output logic [WIDTH-1:0]           Dout,
    output logic [$clog2(DEPTH+1)-1:0] COUNT,
    output logic                       FULL,
    output logic                       EVICT
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    logic do_shift;
    logic do_load;
    logic do_clear;

    logic [WIDTH-1:0] stage_q [DEPTH];
    logic [CW-1:0]    count_q;
    logic             evict_q;

    // Undefined or hold encodings fall through to "no operation".
    always_comb begin
        do_shift = 1'b0;
        do_load  = 1'b0;
        do_clear = 1'b0;
        if (EN) begin
            case (reg_mode_t'(MODE))
                MODE_SHIFT: do_shift = 1'b1;
                MODE_LOAD:  do_load  = 1'b1;
                MODE_CLEAR: do_clear = 1'b1;
                default:    ;
            endcase
        end
    end

    for (genvar i = 0; i < DEPTH; i++) begin : g_stage
        logic [WIDTH-1:0] ser_d;

        if (i == 0) begin : g_head
            assign ser_d = Din;
        end else begin : g_link
            assign ser_d = stage_q[i-1];
        end

        register_stage #(
            .WIDTH (WIDTH)
        ) u_stage (
            .clk     (CLK),
            .rst     (RST),
            .en      (do_shift | do_load),
            .clr     (do_clear),
            .sel_par (do_load),
            .ser_d   (ser_d),
            .par_d   (Pin[i*WIDTH +: WIDTH]),
            .q       (stage_q[i])
        );

        assign Pout[i*WIDTH +: WIDTH] = stage_q[i];
    end

    // Fill level saturates at DEPTH; a shift while full drops
    // the old Dout, which is what EVICT reports next cycle.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            count_q <= '0;
            evict_q <= 1'b0;
        end else begin
            evict_q <= 1'b0;
            if (do_clear) begin
                count_q <= '0;
            end else if (do_load) begin
                count_q <= DEPTH_C;
            end else if (do_shift) begin
                evict_q <= FULL;
                if (!FULL) begin
                    count_q <= count_q + 1'b1;
                end
            end
        end
    end

    assign Dout  = stage_q[DEPTH-1];
    assign COUNT = count_q;
    assign FULL  = (count_q == DEPTH_C);
    assign EVICT = evict_q;

endmodule

// File: tb/tb_register_shift_bank.sv
// Self-checking bench for register_shift_bank (DEPTH=5 and DEPTH=1).
// Expected observations are queued at stimulus time, checked after the edge.
module tb_register_shift_bank;
    import dcnn_reg_pkg::*;

    typedef struct packed {
        logic [79:0] pout;
        logic [15:0] dout;
        logic [2:0]  count;
        logic        full;
        logic        evict;
    } obs_t;

    typedef struct packed {
        logic [7:0] pout;
        logic [7:0] dout;
        logic [0:0] count;
        logic       full;
        logic       evict;
    } obs1_t;

    logic        CLK = 1'b0;
    logic        RST;
    logic        EN;
    logic [1:0]  MODE;
    logic [15:0] Din;
    logic [79:0] Pin;
    logic [79:0] Pout;
    logic [15:0] Dout;
    logic [2:0]  COUNT;
    logic        FULL;
    logic        EVICT;

    logic        EN1;
    logic [1:0]  MODE1;
    logic [7:0]  Din1;
    logic [7:0]  Pin1;
    logic [7:0]  Pout1;
    logic [7:0]  Dout1;
    logic [0:0]  COUNT1;
    logic        FULL1;
    logic        EVICT1;

    int errors = 0;
    int checks = 0;

    obs_t  sb  [$];
    obs1_t sb1 [$];

    logic [15:0] m [5];
    int          mcnt;
    logic        mev;

    always #5 CLK = ~CLK;

    register_shift_bank #(.WIDTH(16), .DEPTH(5)) dut (
        .CLK(CLK), .RST(RST), .EN(EN), .MODE(MODE),
        .Din(Din), .Pin(Pin), .Pout(Pout), .Dout(Dout),
        .COUNT(COUNT), .FULL(FULL), .EVICT(EVICT)
    );

    register_shift_bank #(.WIDTH(8), .DEPTH(1)) dut1 (
        .CLK(CLK), .RST(RST), .EN(EN1), .MODE(MODE1),
        .Din(Din1), .Pin(Pin1), .Pout(Pout1), .Dout(Dout1),
        .COUNT(COUNT1), .FULL(FULL1), .EVICT(EVICT1)
    );

    always @(posedge CLK) begin
        if (RST === 1'b0 && EN === 1'b1)
            assert (!$isunknown(MODE)) else $error("MODE unknown while EN=1");
        if (RST === 1'b0 && EN1 === 1'b1)
            assert (!$isunknown(MODE1)) else $error("MODE1 unknown while EN1=1");
    end

    function automatic obs_t observe();
        return {Pout, Dout, COUNT, FULL, EVICT};
    endfunction

    function automatic obs_t model_obs();
        obs_t o;
        for (int i = 0; i < 5; i++) o.pout[i*16 +: 16] = m[i];
        o.dout  = m[4];
        o.count = 3'(mcnt);
        o.full  = (mcnt == 5);
        o.evict = mev;
        return o;
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < 5; i++) m[i] = '0;
        mcnt = 0;
        mev  = 1'b0;
    endfunction

    function automatic void model_apply(logic en, logic [1:0] mode,
                                        logic [15:0] din, logic [79:0] pin);
        mev = 1'b0;
        if (en) begin
            case (mode)
                2'b01: begin
                    mev = (mcnt == 5);
                    for (int i = 4; i > 0; i--) m[i] = m[i-1];
                    m[0] = din;
                    if (mcnt < 5) mcnt++;
                end
                2'b10: begin
                    for (int i = 0; i < 5; i++) m[i] = pin[i*16 +: 16];
                    mcnt = 5;
                end
                2'b11: begin
                    for (int i = 0; i < 5; i++) m[i] = '0;
                    mcnt = 0;
                end
                default: ;
            endcase
        end
    endfunction

    // Drive one cycle of stimulus, queue its expected result,
    // and return 1 ns after the capturing edge.
    task automatic drive(input logic en, input logic [1:0] mode,
                         input logic [15:0] din, input logic [79:0] pin);
        EN   = en;
        MODE = mode;
        Din  = din;
        Pin  = pin;
        model_apply(en, mode, din, pin);
        sb.push_back(model_obs());
        @(posedge CLK);
        #1;
    endtask

    task automatic test_reset();
        obs_t got;
        RST = 1'b1;
        EN = 1'b0; MODE = 2'b00; Din = '0; Pin = '0;
        EN1 = 1'b0; MODE1 = 2'b00; Din1 = '0; Pin1 = '0;
        model_reset();
        #2;
        got = observe();
        checks++;
        if (got !== obs_t'(0)) begin
            errors++;
            $display("FAIL reset: got %h required %h", got, obs_t'(0));
        end
        @(negedge CLK);
        RST = 1'b0;
        @(posedge CLK);
        #1;
    endtask

    task automatic test_reset_mid();
        obs_t got;
        obs_t exp;
        drive(1'b1, 2'b10, 16'h0, {5{16'hFFFF}});
        got = observe(); exp = sb.pop_front();
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL mid_load: got %h required %h", got, exp);
        end
        EN = 1'b0;
        #3;
        RST = 1'b1;
        model_reset();
        #1;
        checks++;
        if (Pout !== 80'h0 || COUNT !== 3'd0 || FULL !== 1'b0 || EVICT !== 1'b0) begin
            errors++;
            $display("FAIL async_reset: got pout=%h cnt=%0d full=%b ev=%b required all 0",
                     Pout, COUNT, FULL, EVICT);
        end
        #1;
        RST = 1'b0;
        @(posedge CLK);
        #1;
    endtask

    task automatic test_fill();
        obs_t got;
        obs_t exp;
        for (int k = 1; k <= 5; k++) begin
            drive(1'b1, 2'b01, 16'(k), 80'h0);
            got = observe(); exp = sb.pop_front();
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL fill step %0d: got %h required %h", k, got, exp);
            end
        end
        checks++;
        if (Dout !== 16'd1 || COUNT !== 3'd5 || FULL !== 1'b1 ||
            Pout !== {16'd1, 16'd2, 16'd3, 16'd4, 16'd5}) begin
            errors++;
            $display("FAIL fill_final: got dout=%h cnt=%0d full=%b pout=%h required dout=0001 cnt=5 full=1",
                     Dout, COUNT, FULL, Pout);
        end
    endtask

    task automatic test_shift_full();
        obs_t got;
        obs_t exp;
        drive(1'b1, 2'b01, 16'd6, 80'h0);
        got = observe(); exp = sb.pop_front();
        checks++;
        if (got !== exp || Dout !== 16'd2 || EVICT !== 1'b1 || COUNT !== 3'd5) begin
            errors++;
            $display("FAIL shift_full: got %h required %h (dout=0002 evict=1)", got, exp);
        end
        drive(1'b1, 2'b00, 16'd7, 80'h0);
        got = observe(); exp = sb.pop_front();
        checks++;
        if (got !== exp || EVICT !== 1'b0) begin
            errors++;
            $display("FAIL evict_pulse: got %h required %h", got, exp);
        end
    endtask

    task automatic test_enable_gating();
        obs_t got;
        obs_t exp;
        logic [1:0] modes [3] = '{2'b01, 2'b10, 2'b11};
        for (int j = 0; j < 3; j++) begin
            for (int k = 0; k < 3; k++) begin
                drive(1'b0, modes[j], 16'hBEEF, {5{16'h5A5A}});
                got = observe(); exp = sb.pop_front();
                checks++;
                if (got !== exp) begin
                    errors++;
                    $display("FAIL gating mode=%b cyc %0d: got %h required %h",
                             modes[j], k, got, exp);
                end
            end
        end
    endtask

    task automatic test_load_clear();
        obs_t got;
        obs_t exp;
        logic [79:0] p;
        p = {16'hA005, 16'hA004, 16'hA003, 16'hA002, 16'hA001};
        drive(1'b1, 2'b10, 16'h0, p);
        got = observe(); exp = sb.pop_front();
        checks++;
        if (got !== exp || Pout !== p || COUNT !== 3'd5 || EVICT !== 1'b0) begin
            errors++;
            $display("FAIL load: got %h required %h", got, exp);
        end
        drive(1'b1, 2'b11, 16'h1234, p);
        got = observe(); exp = sb.pop_front();
        checks++;
        if (got !== exp || Pout !== 80'h0 || COUNT !== 3'd0 || FULL !== 1'b0) begin
            errors++;
            $display("FAIL clear: got %h required %h", got, exp);
        end
    endtask

    task automatic test_back_to_back();
        obs_t got;
        obs_t exp;
        for (int k = 0; k < 60; k++) begin
            drive(1'($urandom_range(0, 4) != 0), 2'($urandom_range(0, 3)),
                  16'($urandom), {$urandom, $urandom, 16'($urandom)});
            got = observe(); exp = sb.pop_front();
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL random step %0d: got %h required %h", k, got, exp);
            end
        end
    endtask

    task automatic test_depth1();
        obs1_t got;
        obs1_t exp;
        logic [7:0] dins  [3] = '{8'h3C, 8'hC3, 8'h77};
        logic [1:0] mds   [3] = '{2'b01, 2'b01, 2'b00};
        sb1.push_back('{pout: 8'h3C, dout: 8'h3C, count: 1'b1, full: 1'b1, evict: 1'b0});
        sb1.push_back('{pout: 8'hC3, dout: 8'hC3, count: 1'b1, full: 1'b1, evict: 1'b1});
        sb1.push_back('{pout: 8'hC3, dout: 8'hC3, count: 1'b1, full: 1'b1, evict: 1'b0});
        for (int k = 0; k < 3; k++) begin
            EN1 = 1'b1; MODE1 = mds[k]; Din1 = dins[k]; Pin1 = 8'h99;
            @(posedge CLK);
            #1;
            got = {Pout1, Dout1, COUNT1, FULL1, EVICT1};
            exp = sb1.pop_front();
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL depth1 step %0d: got %h required %h", k, got, exp);
            end
        end
        EN1 = 1'b0;
    endtask

    initial begin
        test_reset();
        test_reset_mid();
        test_fill();
        test_shift_full();
        test_enable_gating();
        test_load_clear();
        test_back_to_back();
        test_depth1();
        checks++;
        if (sb.size() != 0 || sb1.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d/%0d left required 0",
                     sb.size(), sb1.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/register_shift_bank.md
Name: register_shift_bank

Overview:
- Parametrised successor to the single 32-bit enabled register: a chain of DEPTH registers, each WIDTH bits wide.
- Supports hold, serial shift-in, parallel load and synchronous clear modes.
- Tracks fill level so downstream logic knows when the window is valid.
- Sits between the feature-map memory reader and the convolution MAC array, holding one kernel-row window (e.g. 3 or 5 pixels).

Parameters:
- WIDTH, 16, bit width of each stage.
- DEPTH, 5, number of stages; legal range 1..16.
- CW, $clog2(DEPTH+1), width of the fill counter; derived, not overridden.

Ports:
- CLK  in  1  rising-edge clock.
- RST  in  1  asynchronous, active-high reset.
- EN  in  1  operation enable; when 0 the bank holds regardless of MODE.
- MODE  in  2  00 hold, 01 shift-in, 10 parallel load, 11 clear.
- Din  in  WIDTH  serial input to stage 0.
- Pin  in  DEPTH*WIDTH  parallel load data; slice i = bits [i*WIDTH +: WIDTH] -> stage i.
- Pout  out  DEPTH*WIDTH  all stages, same slicing as Pin.
- Dout  out  WIDTH  stage DEPTH-1 (oldest word).
- COUNT  out  CW  number of valid words held, 0..DEPTH.
- FULL  out  1  COUNT == DEPTH.
- EVICT  out  1  registered pulse: the previous cycle shifted out a valid word.

Behaviour:
- Reset (RST=1, asynchronous, any time including mid-shift): all stages = 0, COUNT = 0, FULL = 0, EVICT = 0. Outputs reflect reset immediately, without waiting for CLK.
- All state updates on the CLK rising edge when RST=0.
- EN=0: all stages and COUNT hold; EVICT = 0 next cycle.
- EN=1, MODE=00: same as EN=0.
- EN=1, MODE=01 (shift):
  - stage0 <= Din; stage i <= stage i-1 for i = 1..DEPTH-1.
  - COUNT <= min(COUNT+1, DEPTH).
  - EVICT <= (COUNT == DEPTH), i.e. the old Dout was dropped.
- EN=1, MODE=10 (load): stage i <= Pin slice i; COUNT <= DEPTH; EVICT <= 0.
- EN=1, MODE=11 (clear): all stages <= 0; COUNT <= 0; EVICT <= 0. This is a synchronous clear, distinct from RST.
- Latency:
  - Din appears on Pout slice 0 one cycle after a shift.
  - Din appears on Dout after DEPTH consecutive shifts.
  - Pin appears on Pout one cycle after a load.
- FULL is combinational from the COUNT register, so it has no extra latency. EVICT is a registered pulse, high for exactly one cycle per evicting shift.
- COUNT saturates at DEPTH and never wraps. Shifting while full keeps COUNT = DEPTH and FULL = 1.
- DEPTH = 1: a shift writes stage0 directly; Dout = Pout = stage0. After the first shift, every further shift asserts EVICT.
- Stage data is never gated by COUNT. Unfilled stages hold 0 after reset/clear or stale data after a load; consumers qualify data with FULL/COUNT.
- X on MODE while EN=1 is a bench assertion failure. The RTL treats undefined MODE as hold.

Decomposition:
- Shared package dcnn_reg_pkg:
  - MODE encodings: MODE_HOLD, MODE_SHIFT, MODE_LOAD, MODE_CLEAR.
  - Typedef reg_mode_t (2-bit).
- One sub-module, register_stage: WIDTH-bit register with async RST, load enable, synchronous clear and D select (serial neighbour vs parallel slice).
- The bank instantiates DEPTH register_stage instances via generate, plus the COUNT/EVICT control logic.

Test Plan:
- Reset mid-operation: load Pin = {5{16'hFFFF}}, assert RST between clock edges -> Pout = 0, COUNT = 0, FULL = 0 immediately, before the next edge.
- Fill by shifting: shift Din = 1,2,3,4,5 (EN=1, MODE=01) -> COUNT steps 1..5; FULL rises on the 5th edge; Dout = 1; Pout slices 0..4 = 5,4,3,2,1; EVICT stays 0.
- Shift while full: from that state, shift Din = 6 -> Dout = 2, COUNT = 5, EVICT = 1 for exactly one cycle. A following hold cycle -> EVICT = 0.
- Enable gating: EN=0 with MODE = 01, 10 and 11 each held for 3 cycles -> Pout, COUNT and EVICT unchanged (EVICT = 0).
- Load then clear: load Pin = {16'hA005, 16'hA004, 16'hA003, 16'hA002, 16'hA001} -> Pout slice i = A00(i+1), COUNT = 5, EVICT = 0. Next cycle MODE = 11 -> all stages 0, COUNT = 0, FULL = 0.
- DEPTH=1, WIDTH=8 build: shift 8'h3C, then 8'hC3 -> Dout = 3C then C3; COUNT = 1 both times; EVICT = 1 only after the second shift.
